connect4_board_writer: RTL and testbench

- Owns the Connect-4 board state: accepts column drop requests, applies gravity, alternates players, and detects four-in-a-row.
- Drives the three 42-bit bitmaps `color_p0`, `color_p1` and `winner_tokens` consumed by the per-pixel colour logic.
- Bit index is row*7 + col; row 0 is the top row, row 5 the bottom row; col 0 is leftmost.

---
 rtl/connect4_board_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_connect4_board_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_board_writer.sv
// rtl/connect4_board_writer.sv - Connect-4 board state, gravity drop and four-in-a-row scan
module connect4_board_writer #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 new_game,
  input  logic                 drop_valid,
  input  logic [2:0]           drop_col,
  output logic                 drop_ready,
  output logic                 drop_done,
  output logic                 drop_err,
  output logic [ROWS*COLS-1:0] color_p0,
  output logic [ROWS*COLS-1:0] color_p1,
  output logic [ROWS*COLS-1:0] winner_tokens,
  output logic                 current_player,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic [5:0]           move_count
);

  localparam int CELLS = ROWS * COLS;

  // Window shapes anchored at bit 0; shifted to the anchor cell during the scan.
  // Row stride is COLS, so vertical = +7, down-right = +8, down-left = +6.
  localparam logic [CELLS-1:0] H_MASK  = CELLS'(32'h0000_000F);
  localparam logic [CELLS-1:0] V_MASK  = CELLS'(32'h0020_4081);
  localparam logic [CELLS-1:0] DR_MASK = CELLS'(32'h0101_0101);
  localparam logic [CELLS-1:0] DL_MASK = CELLS'(32'h0004_1041);

  typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, OVER} state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] color_p0_q, color_p0_d;
  logic [CELLS-1:0] color_p1_q, color_p1_d;
  logic [CELLS-1:0] winner_tokens_q, winner_tokens_d;
  logic [CELLS-1:0] acc_q, acc_d;
  logic             current_player_q, current_player_d;
  logic             game_over_q, game_over_d;
  logic [1:0]       winner_q, winner_d;
  logic [5:0]       move_count_q, move_count_d;
  logic [2:0]       scan_row_q, scan_row_d;
  logic [2:0]       scan_col_q, scan_col_d;
  logic             drop_done_q, drop_done_d;
  logic             drop_err_q, drop_err_d;

  logic [ROWS-1:0][COLS-1:0] occ_grid;
  logic [ROWS-1:0]           col_occ;
  logic                      col_in_range;
  logic                      drop_legal;
  logic [2:0]                drop_row;
  logic [5:0]                drop_bit;
  logic [CELLS-1:0]          drop_mask;
  logic [CELLS-1:0]          mover_bits;
  logic [5:0]                scan_base;
  logic [CELLS-1:0]          scan_hits;
  logic                      scan_last;

  assign occ_grid     = color_p0_q | color_p1_q;
  assign col_occ      = {occ_grid[5][drop_col], occ_grid[4][drop_col], occ_grid[3][drop_col],
                         occ_grid[2][drop_col], occ_grid[1][drop_col], occ_grid[0][drop_col]};
  assign col_in_range = (drop_col <= 3'(COLS - 1));
  assign drop_legal   = col_in_range && !col_occ[0];
  assign drop_bit     = {3'b000, drop_row} * 6'(COLS) + {3'b000, drop_col};
  assign drop_mask    = CELLS'(1) << drop_bit;
  assign mover_bits   = current_player_q ? color_p1_q : color_p0_q;
  assign scan_base    = {3'b000, scan_row_q} * 6'(COLS) + {3'b000, scan_col_q};
  assign scan_last    = (scan_row_q == 3'(ROWS - 1)) && (scan_col_q == 3'(COLS - 1));

  // Gravity: the lowest (largest-index) empty row of the requested column
  always_comb begin
    drop_row = 3'd0;
    if      (!col_occ[5]) drop_row = 3'd5;
    else if (!col_occ[4]) drop_row = 3'd4;
    else if (!col_occ[3]) drop_row = 3'd3;
    else if (!col_occ[2]) drop_row = 3'd2;
    else if (!col_occ[1]) drop_row = 3'd1;
  end

  // Fully-owned windows anchored at the current scan cell, mover's tokens only
  always_comb begin
    scan_hits = '0;
    if (scan_col_q <= 3'(COLS - WIN_LEN) &&
        (mover_bits & (H_MASK << scan_base)) == (H_MASK << scan_base))
      scan_hits = scan_hits | (H_MASK << scan_base);
    if (scan_row_q <= 3'(ROWS - WIN_LEN) &&
        (mover_bits & (V_MASK << scan_base)) == (V_MASK << scan_base))
      scan_hits = scan_hits | (V_MASK << scan_base);
    if (scan_row_q <= 3'(ROWS - WIN_LEN) && scan_col_q <= 3'(COLS - WIN_LEN) &&
        (mover_bits & (DR_MASK << scan_base)) == (DR_MASK << scan_base))
      scan_hits = scan_hits | (DR_MASK << scan_base);
    if (scan_row_q <= 3'(ROWS - WIN_LEN) && scan_col_q >= 3'(WIN_LEN - 1) &&
        (mover_bits & (DL_MASK << scan_base)) == (DL_MASK << scan_base))
      scan_hits = scan_hits | (DL_MASK << scan_base);
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; new_game forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drop_valid && drop_legal) state_d = CHECK;
      CHECK:   if (scan_last) state_d = RESOLVE;
      RESOLVE: if (acc_q != '0 || move_count_q == 6'(CELLS)) state_d = OVER;
               else state_d = IDLE;
      default: state_d = OVER;
    endcase
    if (new_game) state_d = IDLE;
  end

  // FSM outputs and board datapath next values
  always_comb begin
    color_p0_d       = color_p0_q;
    color_p1_d       = color_p1_q;
    winner_tokens_d  = winner_tokens_q;
    acc_d            = acc_q;
    current_player_d = current_player_q;
    game_over_d      = game_over_q;
    winner_d         = winner_q;
    move_count_d     = move_count_q;
    scan_row_d       = scan_row_q;
    scan_col_d       = scan_col_q;
    drop_done_d      = 1'b0;
    drop_err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (drop_valid) begin
          if (!drop_legal) begin
            drop_err_d = 1'b1;
          end else begin
            if (current_player_q) color_p1_d = color_p1_q | drop_mask;
            else                  color_p0_d = color_p0_q | drop_mask;
            move_count_d = move_count_q + 6'd1;
            scan_row_d   = 3'd0;
            scan_col_d   = 3'd0;
            acc_d        = '0;
          end
        end
      end
      CHECK: begin
        acc_d = acc_q | scan_hits;
        if (scan_col_q == 3'(COLS - 1)) begin
          scan_col_d = 3'd0;
          scan_row_d = scan_row_q + 3'd1;
        end else begin
          scan_col_d = scan_col_q + 3'd1;
        end
      end
      RESOLVE: begin
        drop_done_d = 1'b1;
        if (acc_q != '0) begin
          winner_tokens_d = acc_q;
          winner_d        = current_player_q ? 2'b10 : 2'b01;
          game_over_d     = 1'b1;
        end else if (move_count_q == 6'(CELLS)) begin
          winner_d    = 2'b11;
          game_over_d = 1'b1;
        end else begin
          current_player_d = ~current_player_q;
        end
      end
      default: ;
    endcase
    if (new_game) begin
      color_p0_d       = '0;
      color_p1_d       = '0;
      winner_tokens_d  = '0;
      acc_d            = '0;
      current_player_d = 1'b0;
      game_over_d      = 1'b0;
      winner_d         = 2'b00;
      move_count_d     = 6'd0;
      scan_row_d       = 3'd0;
      scan_col_d       = 3'd0;
      drop_done_d      = 1'b0;
      drop_err_d       = 1'b0;
    end
  end

  // Board datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      color_p0_q       <= '0;
      color_p1_q       <= '0;
      winner_tokens_q  <= '0;
      acc_q            <= '0;
      current_player_q <= 1'b0;
      game_over_q      <= 1'b0;
      winner_q         <= 2'b00;
      move_count_q     <= 6'd0;
      scan_row_q       <= 3'd0;
      scan_col_q       <= 3'd0;
      drop_done_q      <= 1'b0;
      drop_err_q       <= 1'b0;
    end else begin
      color_p0_q       <= color_p0_d;
      color_p1_q       <= color_p1_d;
      winner_tokens_q  <= winner_tokens_d;
      acc_q            <= acc_d;
      current_player_q <= current_player_d;
      game_over_q      <= game_over_d;
      winner_q         <= winner_d;
      move_count_q     <= move_count_d;
      scan_row_q       <= scan_row_d;
      scan_col_q       <= scan_col_d;
      drop_done_q      <= drop_done_d;
      drop_err_q       <= drop_err_d;
    end
  end

  assign drop_ready     = (state_q == IDLE);
  assign drop_done      = drop_done_q;
  assign drop_err       = drop_err_q;
  assign color_p0       = color_p0_q;
  assign color_p1       = color_p1_q;
  assign winner_tokens  = winner_tokens_q;
  assign current_player = current_player_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;
  assign move_count     = move_count_q;

endmodule

// File: tb/tb_connect4_board_writer.sv
// tb/tb_connect4_board_writer.sv - self-checking bench for connect4_board_writer
module tb_connect4_board_writer;

  logic        Clk = 1'b0;
  logic        Reset, new_game, drop_valid;
  logic [2:0]  drop_col;
  logic        drop_ready, drop_done, drop_err, current_player, game_over;
  logic [41:0] color_p0, color_p1, winner_tokens;
  logic [1:0]  winner;
  logic [5:0]  move_count;

  always #5 Clk = ~Clk;

  connect4_board_writer dut (
    .Clk(Clk), .Reset(Reset), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
    .drop_done(drop_done), .drop_err(drop_err),
    .color_p0(color_p0), .color_p1(color_p1), .winner_tokens(winner_tokens),
    .current_player(current_player), .game_over(game_over),
    .winner(winner), .move_count(move_count)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference board
  logic [41:0] m_p0, m_p1, m_wt;
  logic        m_pl, m_over;
  logic [1:0]  m_win;
  logic [5:0]  m_cnt;

  typedef struct {
    bit          is_err;
    logic [41:0] p0, p1, wt;
    logic        pl, over;
    logic [1:0]  win;
    logic [5:0]  cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         ng;
    logic [2:0] col;
    bit         err;
    logic [1:0] win;
    logic [5:0] cnt;
    logic       pl;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input int ng, input int col, input int err,
                              input int win, input int cnt, input int pl);
    vec_t v;
    v.ng = (ng != 0); v.col = 3'(col); v.err = (err != 0);
    v.win = 2'(win); v.cnt = 6'(cnt); v.pl = (pl != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All four-in-a-row windows of a bitmap, walked by coordinates
  function automatic logic [41:0] model_wins(input logic [41:0] b);
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    logic [41:0] m = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          int er, ec;
          er = r + 3 * drs[d];
          ec = c + 3 * dcs[d];
          if (er <= 5 && ec >= 0 && ec <= 6) begin
            logic [41:0] w;
            bit all;
            w = '0; all = 1;
            for (int k = 0; k < 4; k++) begin
              int idx;
              idx = (r + k * drs[d]) * 7 + c + k * dcs[d];
              if (!b[idx]) all = 0;
              w[idx] = 1'b1;
            end
            if (all) m = m | w;
          end
        end
    return m;
  endfunction

  task automatic model_clear();
    m_p0 = '0; m_p1 = '0; m_wt = '0; m_pl = 0; m_over = 0; m_win = 2'b00; m_cnt = 0;
  endtask

  task automatic model_drop(input logic [2:0] col, output exp_t e);
    logic [41:0] occ, wins;
    int row;
    occ = m_p0 | m_p1;
    e.is_err = 0;
    if (col > 3'd6 || occ[int'(col)]) begin
      e.is_err = 1;
    end else begin
      row = 0;
      for (int r = 5; r >= 0; r--)
        if (!occ[r * 7 + int'(col)]) begin row = r; break; end
      if (m_pl) m_p1[row * 7 + int'(col)] = 1'b1;
      else      m_p0[row * 7 + int'(col)] = 1'b1;
      m_cnt = m_cnt + 6'd1;
      wins = model_wins(m_pl ? m_p1 : m_p0);
      if (wins != '0) begin
        m_wt = wins; m_win = m_pl ? 2'b10 : 2'b01; m_over = 1;
      end else if (m_cnt == 6'd42) begin
        m_win = 2'b11; m_over = 1;
      end else begin
        m_pl = ~m_pl;
      end
    end
    e.p0 = m_p0; e.p1 = m_p1; e.wt = m_wt; e.pl = m_pl;
    e.over = m_over; e.win = m_win; e.cnt = m_cnt;
  endtask

  task automatic check_resp(input int n, output bit saw_err);
    exp_t e;
    e = sb.pop_front();
    saw_err = drop_err;
    chk("resp_err", drop_err, e.is_err);
    chk("resp_done", drop_done, !e.is_err);
    chk("resp_latency", n, e.is_err ? 0 : 43);
    chk("color_p0", color_p0, e.p0);
    chk("color_p1", color_p1, e.p1);
    chk("winner_tokens", winner_tokens, e.wt);
    chk("current_player", current_player, e.pl);
    chk("game_over", game_over, e.over);
    chk("winner", winner, e.win);
    chk("move_count", move_count, e.cnt);
    chk("drop_ready_after", drop_ready, !e.over);
    @(posedge Clk); #1;
    chk("pulse_one_cycle", {drop_done, drop_err}, 2'b00);
  endtask

  task automatic drop(input logic [2:0] col, output bit saw_err);
    exp_t e;
    int n;
    bit got;
    saw_err = 0;
    chk("ready_before_drop", drop_ready, 1);
    model_drop(col, e);
    sb.push_back(e);
    @(negedge Clk); drop_valid = 1; drop_col = col;
    @(posedge Clk); #1; drop_valid = 0;
    n = 0; got = 0;
    while (!got && n < 60) begin
      if (drop_done || drop_err) got = 1;
      else begin @(posedge Clk); #1; n++; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL drop_timeout col=%0d: got no response in 60 cycles, required drop_done or drop_err", col);
      void'(sb.pop_front());
    end else begin
      check_resp(n, saw_err);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_p0"}, color_p0, 0);
    chk({tag, "_p1"}, color_p1, 0);
    chk({tag, "_wt"}, winner_tokens, 0);
    chk({tag, "_player"}, current_player, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_count"}, move_count, 0);
    chk({tag, "_pulses"}, {drop_done, drop_err}, 0);
    chk({tag, "_ready"}, drop_ready, 1);
  endtask

  task automatic pulse_new_game();
    @(negedge Clk); new_game = 1;
    @(posedge Clk); #1; new_game = 0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   e_flag;
    int   seen;
    int   draw_cols[$];
    logic [41:0] p0_hold, p1_hold;

    Reset = 1; new_game = 0; drop_valid = 0; drop_col = 0;
    model_clear();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("reset");
    @(negedge Clk); Reset = 0;

    // ng, col, err, winner, count, player after the move
    tbl.push_back(mk(1, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4, 0));
    tbl.push_back(mk(0, 2, 0, 0, 5, 1));
    tbl.push_back(mk(0, 2, 0, 0, 6, 0));
    tbl.push_back(mk(0, 3, 0, 1, 7, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5, 1));
    tbl.push_back(mk(0, 0, 0, 0, 6, 0));
    tbl.push_back(mk(0, 0, 1, 0, 6, 0));
    tbl.push_back(mk(0, 7, 1, 0, 6, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5, 1));
    tbl.push_back(mk(0, 1, 0, 0, 6, 0));
    tbl.push_back(mk(0, 2, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 2, 8, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ng) begin
        pulse_new_game();
        check_reset_vals("new_game");
      end
      drop(tbl[i].col, e_flag);
      chk("tbl_err", e_flag, tbl[i].err);
      chk("tbl_winner", winner, tbl[i].win);
      chk("tbl_count", move_count, tbl[i].cnt);
      chk("tbl_player", current_player, tbl[i].pl);
      if (i == 1) begin
        chk("first_p0_bit38", color_p0, 42'h1 << 38);
        chk("first_p1_bit31", color_p1, 42'h1 << 31);
      end
      if (i == 8) begin
        chk("row_win_tokens", winner_tokens, 42'hF << 35);
        chk("row_win_over", game_over, 1);
        p0_hold = color_p0; p1_hold = color_p1;
        @(negedge Clk); drop_valid = 1; drop_col = 3'd4;
        @(negedge Clk); drop_valid = 0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge Clk);
          if (drop_done || drop_err) seen++;
        end
        chk("over_no_response", seen, 0);
        chk("over_p0_hold", color_p0, p0_hold);
        chk("over_p1_hold", color_p1, p1_hold);
        chk("over_ready_low", drop_ready, 0);
      end
      if (i == 24)
        chk("col_win_tokens", winner_tokens,
            (42'h1 << 15) | (42'h1 << 22) | (42'h1 << 29) | (42'h1 << 36));
      if (i == 6) chk("no_overlap", color_p0 & color_p1, 0);
    end

    // Full board with no four-in-a-row at any point
    pulse_new_game();
    for (int k = 0; k < 6; k++) draw_cols.push_back(0);
    for (int k = 0; k < 6; k++) draw_cols.push_back(1);
    draw_cols.push_back(4);
    for (int k = 0; k < 6; k++) draw_cols.push_back(2);
    for (int k = 0; k < 6; k++) draw_cols.push_back(3);
    for (int k = 0; k < 5; k++) draw_cols.push_back(4);
    draw_cols.push_back(5);
    for (int k = 0; k < 6; k++) draw_cols.push_back(6);
    for (int k = 0; k < 5; k++) draw_cols.push_back(5);
    foreach (draw_cols[k]) drop(3'(draw_cols[k]), e_flag);
    chk("draw_winner", winner, 2'b11);
    chk("draw_over", game_over, 1);
    chk("draw_count", move_count, 42);
    chk("draw_full", color_p0 | color_p1, {42{1'b1}});
    chk("draw_no_overlap", color_p0 & color_p1, 0);

    // new_game while in OVER
    pulse_new_game();
    check_reset_vals("ng_over");
    drop(3'd3, e_flag);
    chk("ng_fresh_bit38", color_p0, 42'h1 << 38);

    // Reset in the middle of CHECK
    @(negedge Clk); drop_valid = 1; drop_col = 3'd2;
    @(negedge Clk); drop_valid = 0;
    repeat (10) @(negedge Clk);
    chk("in_check_not_ready", drop_ready, 0);
    Reset = 1;
    @(posedge Clk); #1;
    Reset = 0;
    model_clear();
    check_reset_vals("reset_check");
    drop(3'd3, e_flag);
    chk("reset_fresh_bit38", color_p0, 42'h1 << 38);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
